// File: rtl/afpm_rr_scheduler_if.sv
// Bus bundle for the FP16 multiplier scheduler: requester operands, core start/done
// handshake and the tagged response port.
interface afpm_rr_scheduler_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [16*NREQ-1:0]   req_a;
    logic [16*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 mul_start;
    logic [15:0]          mul_a;
    logic [15:0]          mul_b;
    logic                 mul_done;
    logic [15:0]          mul_result;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [15:0]          rsp_data;
    logic                 rsp_err;
    logic                 rsp_ready;
    logic                 busy;

    // The scheduler is the slave side.
    modport slave (
        input  req_valid, req_a, req_b, mul_done, mul_result, rsp_ready,
        output req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_data,
               rsp_err, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_done, mul_result, rsp_ready,
        input  req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_data,
               rsp_err, busy
    );
endinterface

// File: rtl/afpm_rr_scheduler.sv
// Round-robin scheduler sharing one log-domain FP16 multiplier core between NREQ
// requesters, with a zero-operand bypass and a done timeout.
module afpm_rr_scheduler #(
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int TIMEOUT     = 15,
    parameter int ZERO_BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    afpm_rr_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state_reg;
    logic [IDW-1:0]  ptr_reg;
    logic [IDW-1:0]  id_reg;
    logic [7:0]      timer_reg;
    logic [15:0]     a_reg;
    logic [15:0]     b_reg;
    logic [15:0]     data_reg;
    logic            err_reg;

    logic [15:0]     op_a [NREQ];
    logic [15:0]     op_b [NREQ];
    logic [NREQ-1:0] upper_valid;
    logic [NREQ-1:0] req_ready_w;
    logic            grant_valid;
    logic            grant_found;
    logic [IDW-1:0]  grant_id;
    logic [15:0]     grant_a;
    logic [15:0]     grant_b;
    logic            grant_bypass;
    logic            core_phase;
    logic            resp_phase;

    // upper_valid marks requesters at or above the pointer; they get first pick.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign op_a[gi]        = bus.req_a[16*gi +: 16];
            assign op_b[gi]        = bus.req_b[16*gi +: 16];
            assign upper_valid[gi] = bus.req_valid[gi] && (IDW'(gi) >= ptr_reg);
            assign req_ready_w[gi] = (state_reg == S_IDLE) && grant_valid &&
                                     (grant_id == IDW'(gi));
        end
    endgenerate

    assign grant_valid = |bus.req_valid;

    always_comb begin
        grant_id    = '0;
        grant_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && upper_valid[i]) begin
                grant_id    = IDW'(i);
                grant_found = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && bus.req_valid[i]) begin
                grant_id    = IDW'(i);
                grant_found = 1'b1;
            end
        end
        grant_a = '0;
        grant_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                grant_a = op_a[i];
                grant_b = op_b[i];
            end
        end
    end

    // The log datapath has no encoding for zero, so a signed zero is produced here.
    assign grant_bypass = (ZERO_BYPASS != 0) &&
                          ((grant_a[14:0] == 15'h0) || (grant_b[14:0] == 15'h0));

    assign core_phase = (state_reg == S_ISSUE) || (state_reg == S_WAIT);
    assign resp_phase = (state_reg == S_RESP);

    assign bus.req_ready = req_ready_w;
    assign bus.mul_start = (state_reg == S_ISSUE);
    assign bus.mul_a     = core_phase ? a_reg : 16'h0;
    assign bus.mul_b     = core_phase ? b_reg : 16'h0;
    assign bus.rsp_valid = resp_phase;
    assign bus.rsp_id    = resp_phase ? id_reg : '0;
    assign bus.rsp_data  = resp_phase ? data_reg : 16'h0;
    assign bus.rsp_err   = resp_phase ? err_reg : 1'b0;
    assign bus.busy      = (state_reg != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            ptr_reg   <= '0;
            id_reg    <= '0;
            timer_reg <= 8'd0;
            a_reg     <= 16'h0;
            b_reg     <= 16'h0;
            data_reg  <= 16'h0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (grant_valid) begin
                        a_reg  <= grant_a;
                        b_reg  <= grant_b;
                        id_reg <= grant_id;
                        if (grant_bypass) begin
                            data_reg  <= {grant_a[15] ^ grant_b[15], 15'h0};
                            err_reg   <= 1'b0;
                            state_reg <= S_RESP;
                        end else begin
                            state_reg <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    timer_reg <= 8'd0;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the timeout cycle still wins.
                    if (bus.mul_done) begin
                        data_reg  <= bus.mul_result;
                        err_reg   <= 1'b0;
                        state_reg <= S_RESP;
                    end else if (timer_reg == 8'(TIMEOUT - 1)) begin
                        data_reg  <= 16'h7E00;
                        err_reg   <= 1'b1;
                        state_reg <= S_RESP;
                    end else begin
                        timer_reg <= timer_reg + 8'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        ptr_reg   <= (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + IDW'(1);
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_afpm_rr_scheduler.sv
// Randomized bench for afpm_rr_scheduler against a job-level reference model
// (round-robin pointer, latency rules, bypass/timeout results).
module tb_afpm_rr_scheduler;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    afpm_rr_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus_if ();

    afpm_rr_scheduler #(
        .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT), .ZERO_BYPASS(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          jobs     = 0;
    int          model_ptr = 0;
    logic [15:0] opa [NREQ];
    logic [15:0] opb [NREQ];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Stand-in for the log multiplier: add biased magnitudes, xor signs.
    function automatic logic [15:0] fake_mul(input logic [15:0] a, input logic [15:0] b);
        logic [14:0] m;
        m = a[14:0] + b[14:0] - 15'h3C00;
        return {a[15] ^ b[15], m};
    endfunction

    function automatic int model_grant(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (model_ptr + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [15:0] rand_op();
        int r;
        logic [15:0] v;
        r = $urandom_range(0, 9);
        if (r == 0) return 16'h0000;
        if (r == 1) return 16'h8000;
        v = 16'($urandom);
        if (v[14:0] == 15'h0) v[0] = 1'b1;
        return v;
    endfunction

    task automatic drive_ops(input logic [NREQ-1:0] valid);
        bus_if.req_valid = valid;
        for (int i = 0; i < NREQ; i++) begin
            bus_if.req_a[16*i +: 16] = opa[i];
            bus_if.req_b[16*i +: 16] = opb[i];
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req_ready"}, 32'(bus_if.req_ready), 32'h0);
        check_eq({tag, "_mul_start"}, 32'(bus_if.mul_start), 32'h0);
        check_eq({tag, "_mul_a"},     32'(bus_if.mul_a),     32'h0);
        check_eq({tag, "_mul_b"},     32'(bus_if.mul_b),     32'h0);
        check_eq({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid), 32'h0);
        check_eq({tag, "_rsp_id"},    32'(bus_if.rsp_id),    32'h0);
        check_eq({tag, "_rsp_data"},  32'(bus_if.rsp_data),  32'h0);
        check_eq({tag, "_rsp_err"},   32'(bus_if.rsp_err),   32'h0);
        check_eq({tag, "_busy"},      32'(bus_if.busy),      32'h0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the
    // response handshake. d = WAIT cycles before mul_done (>= TIMEOUT: never in time).
    task automatic run_job(input logic [NREQ-1:0] valid, input int d, input int stall,
                           input bit junk);
        int          g;
        int          lat;
        bit          byp;
        bit          err_exp;
        bit          real_done;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] edata;

        g       = model_grant(valid);
        ea      = opa[g];
        eb      = opb[g];
        byp     = (ea[14:0] == 15'h0) || (eb[14:0] == 15'h0);
        err_exp = !byp && (d >= TIMEOUT);
        lat     = byp ? 1 : ((d < TIMEOUT) ? 3 + d : TIMEOUT + 2);
        edata   = byp ? {ea[15] ^ eb[15], 15'h0} : (err_exp ? 16'h7E00 : fake_mul(ea, eb));

        drive_ops(valid);
        bus_if.mul_done   = 1'b0;
        bus_if.rsp_ready  = 1'b0;
        bus_if.mul_result = 16'($urandom);
        #1;
        check_eq("grant_ready", 32'(bus_if.req_ready), 32'(1 << g));
        check_eq("idle_busy",   32'(bus_if.busy),      32'h0);
        check_eq("idle_start",  32'(bus_if.mul_start), 32'h0);
        check_eq("idle_rsp",    32'(bus_if.rsp_valid), 32'h0);

        for (int c = 1; c <= lat + stall; c++) begin
            @(negedge clk);
            real_done         = !byp && (c == 2 + d);
            bus_if.mul_done   = real_done || (junk && (c == 1 || c >= lat) && ($urandom_range(0, 1) == 1));
            bus_if.mul_result = real_done ? fake_mul(ea, eb) : 16'($urandom);
            bus_if.rsp_ready  = (c >= lat + stall);
            #1;
            check_eq("mul_start", 32'(bus_if.mul_start), 32'(!byp && c == 1));
            check_eq("mul_a",     32'(bus_if.mul_a),     (!byp && c < lat) ? 32'(ea) : 32'h0);
            check_eq("mul_b",     32'(bus_if.mul_b),     (!byp && c < lat) ? 32'(eb) : 32'h0);
            check_eq("busy",      32'(bus_if.busy),      32'h1);
            check_eq("req_ready_busy", 32'(bus_if.req_ready), 32'h0);
            check_eq("rsp_valid", 32'(bus_if.rsp_valid), 32'(c >= lat));
            check_eq("rsp_id",    32'(bus_if.rsp_id),    (c >= lat) ? 32'(g) : 32'h0);
            check_eq("rsp_data",  32'(bus_if.rsp_data),  (c >= lat) ? 32'(edata) : 32'h0);
            check_eq("rsp_err",   32'(bus_if.rsp_err),   (c >= lat) ? 32'(err_exp) : 32'h0);
        end
        model_ptr = (g + 1) % NREQ;
        jobs++;
        $display("job %0d id=%0d a=%h b=%h bypass=%0d d=%0d lat=%0d data=%h err=%0d",
                 jobs, g, ea, eb, byp, d, lat, edata, err_exp);
        @(negedge clk);
        bus_if.mul_done  = 1'b0;
        bus_if.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] v;
        int              d;
        int              r;

        for (int i = 0; i < NREQ; i++) begin
            opa[i] = 16'h3C00;
            opb[i] = 16'h3C00;
        end
        drive_ops('0);
        bus_if.mul_done   = 1'b0;
        bus_if.mul_result = 16'h0;
        bus_if.rsp_ready  = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic core job: 1.0 * 2.0, done after 2 WAIT cycles.
        opa[0] = 16'h3C00; opb[0] = 16'h4000;
        run_job(4'b0001, 2, 0, 1'b0);

        // All requesters busy: grant walks round-robin.
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = 16'h3C00 + 16'(i);
            opb[i] = 16'h4100 + 16'(i);
        end
        for (int j = 0; j < 6; j++) run_job(4'b1111, 0, 0, 1'b0);

        // Negative zero bypasses the core.
        opa[2] = 16'h8000; opb[2] = 16'h3C00;
        run_job(4'b0100, 0, 0, 1'b0);

        // Core never answers in time.
        opa[1] = 16'h4200; opb[1] = 16'h4400;
        run_job(4'b0010, TIMEOUT, 0, 1'b0);

        // Consumer stalls with all requesters pending and stray done pulses.
        opa[2] = 16'h4500; opb[2] = 16'hC400;
        run_job(4'b1111, 1, 5, 1'b1);

        // Reset in the middle of WAIT abandons the job.
        opa[0] = 16'h3E00; opb[0] = 16'h3E00;
        run_job(4'b0001, 0, 0, 1'b0);
        opa[2] = 16'h4200; opb[2] = 16'h4400;
        drive_ops(4'b0100);
        #1;
        check_eq("rst_pre_grant", 32'(bus_if.req_ready), 32'h4);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drive_ops('0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        bus_if.mul_done   = 1'b1;
        bus_if.mul_result = 16'h1234;
        @(negedge clk);
        bus_if.mul_done = 1'b0;
        #1;
        check_eq("rst_late_done_busy", 32'(bus_if.busy),      32'h0);
        check_eq("rst_late_done_rsp",  32'(bus_if.rsp_valid), 32'h0);
        model_ptr = 0;
        run_job(4'b1111, 1, 0, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 40; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                opa[i] = rand_op();
                opb[i] = rand_op();
            end
            v = NREQ'($urandom);
            if (v == '0) v = NREQ'(1 << $urandom_range(0, NREQ - 1));
            r = $urandom_range(0, 7);
            d = (r == 0) ? TIMEOUT : ((r < 3) ? $urandom_range(0, TIMEOUT - 1) : $urandom_range(0, 4));
            run_job(v, d, $urandom_range(0, 3), ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/afpm_rr_scheduler.md
Name: afpm_rr_scheduler

Overview:
- Round-robin scheduler that shares one logarithmic FP16 approximate multiplier core between NREQ requesters.
- Accepts operand pairs over valid/ready, issues one start pulse to the core, and waits for its done strobe (with a timeout).
- Returns a tagged result over a valid/ready response port.
- Sits between the byte-collection front ends and the single multiplier datapath. Bypasses the core for ±0 operands, which the log datapath cannot represent.

Parameters:
- NREQ, 4: number of requesters (2..8).
- IDW, 2: requester ID width; must equal clog2(NREQ).
- TIMEOUT, 15: WAIT cycles without mul_done before an error response (1..255).
- ZERO_BYPASS, 1: 1 = a ±0 operand skips the core.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  16*NREQ  FP16 operand A; requester i on bits [16i+15:16i].
- req_b  in  16*NREQ  FP16 operand B, same packing.
- req_ready  out  NREQ  one-hot accept.
- mul_start  out  1  one-cycle start pulse to the core.
- mul_a  out  16  operand A to the core.
- mul_b  out  16  operand B to the core.
- mul_done  in  1  core result-valid strobe.
- mul_result  in  16  core FP16 product.
- rsp_valid  out  1  response valid.
- rsp_id  out  IDW  requester index of the response.
- rsp_data  out  16  FP16 product.
- rsp_err  out  1  1 = core timeout.
- rsp_ready  in  1  response consumer ready.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (rst high at a clk edge) forces:
  - state=IDLE, ptr=0, timer=0.
  - Latched a, b, id, data, err all 0.
  - All outputs 0.
  - Reset mid-operation abandons the job; no response is produced, and a later mul_done is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = first i with req_valid[i], searching ptr, ptr+1, ... modulo NREQ.
  - req_ready[grant]=1 combinationally, only in IDLE; all other bits 0.
  - On handshake: latch a, b and id=grant.
  - Next state is RESP if ZERO_BYPASS and (a[14:0]==0 or b[14:0]==0). In that case data={a[15]^b[15], 15'h0}, err=0.
  - Otherwise next state is ISSUE.
  - No valid requester: stay in IDLE.
- ISSUE:
  - mul_start=1 for exactly this cycle; timer cleared.
  - Next state is WAIT.
  - mul_done during ISSUE is ignored.
- WAIT:
  - mul_done=1: capture data=mul_result, err=0, go to RESP.
  - Else, if timer==TIMEOUT-1: data=16'h7E00 (qNaN), err=1, go to RESP.
  - Else timer+1, stay in WAIT.
  - An error is therefore flagged after exactly TIMEOUT WAIT cycles without done.
  - mul_done in the same cycle as the timeout wins (normal result).
- mul_a/mul_b drive the latched operands in ISSUE and WAIT; 0 otherwise.
- RESP:
  - rsp_valid=1, with rsp_id/rsp_data/rsp_err held stable until rsp_ready.
  - On handshake: ptr <= (id==NREQ-1) ? 0 : id+1, go to IDLE.
  - rsp_valid is never withdrawn without a handshake.
- Outputs: rsp_* are registered; rsp_id/data/err are 0 outside RESP. mul_start and req_ready are decoded from state.
- Latency, acceptance cycle to first rsp_valid cycle:
  - Bypass: 1.
  - Core: 3 + d, where d = WAIT cycles before mul_done (d=0 means done in the first WAIT cycle).
- Throughput: at most one job in flight. A new request is accepted no earlier than the cycle after the response handshake.
- mul_done outside WAIT is ignored in every state.

Test Plan:
- Req0 a=16'h3C00, b=16'h4000; model returns 16'h4000 at d=2; rsp_ready=1 -> mul_start high exactly one cycle; mul_a=3C00, mul_b=4000; rsp_valid 5 cycles after accept; rsp_id=0, rsp_data=4000, rsp_err=0.
- All four req_valid held high; core d=0; rsp_ready=1 -> grant order 0,1,2,3,0,1; each req_ready one-hot and only in IDLE.
- Req2 a=16'h8000, b=16'h3C00 -> no mul_start; rsp_valid the cycle after accept; rsp_id=2, rsp_data=16'h8000.
- mul_done never asserted, TIMEOUT=15 -> rsp_err=1 and rsp_data=16'h7E00 after exactly 15 WAIT cycles; busy high throughout.
- rsp_ready held low 5 cycles in RESP with req_valid=4'hF -> rsp_* stable; req_ready=0; mul_start=0; core pulses mul_done -> no state change.
- rst pulsed during WAIT, then mul_done pulsed -> all outputs 0 the cycle after reset; no response; next request granted from ptr=0.
